// File: rtl/mem16_bridge32.sv
// -----------------------------------------------------------------------------
// mem16_bridge32
//
// Initiator-side bridge between a 32-bit load/store requester and a 16-bit
// single-port data memory with combinational read and posedge write. Each
// aligned 32-bit access becomes two 16-bit memory accesses: the low half at A,
// then the high half at A+HALF_STRIDE (mod 2^16). One response is returned per
// request over a valid/ready handshake. Misaligned requests (A[1:0] != 0) get
// an immediate error response and never touch the memory.
//
// Parameters
//   HALF_STRIDE       address offset of the high half. It must be a multiple of
//                     4 so that both halves land on word-aligned memory slots.
//
// Ports
//   clk               single clock; all state updates on posedge
//   rst               synchronous, active-high reset
//   req_valid         request present
//   req_ready         bridge can accept (high only in IDLE)
//   req_addr   [15:0] byte address of the 32-bit access
//   req_we            1 = write, 0 = read
//   req_wdata  [31:0] write data
//   resp_valid        response present
//   resp_ready        requester accepts the response
//   resp_rdata [31:0] read data {hi,lo}; 0 for writes and errors
//   resp_err          1 = misaligned request, no memory access made
//   mem_address      [15:0] memory address
//   mem_write_data   [15:0] memory write data
//   mem_write_enable        memory write enable
//   mem_read_data    [15:0] memory read data (combinational)
// -----------------------------------------------------------------------------
module mem16_bridge32 #(
  parameter logic [15:0] HALF_STRIDE = 16'd4
) (
  input  logic        clk,
  input  logic        rst,
  // Requester side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // Memory side
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [15:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q;

  // Request captured in IDLE. Only the upper write half is kept: the lower half
  // is driven to the memory directly from req_wdata on the accepting edge.
  logic [15:0] addr_q;
  logic        we_q;
  logic [15:0] wdata_hi_q;

  // Low half of a read, captured at the edge that ends LO.
  logic [15:0] lo_q;

  // Registered outputs
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [15:0] mem_address_q;
  logic [15:0] mem_write_data_q;
  logic        mem_write_enable_q;

  // ---------------------------------------------------------------------------
  // Sequencer. All memory-side and response-side outputs are loaded on the
  // edge that enters the state in which they are valid, so they are glitch-free
  // registered values throughout that state.
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignments so that all of them
  // see the pre-edge values of each other, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      addr_q             <= '0;
      we_q               <= 1'b0;
      wdata_hi_q         <= '0;
      lo_q               <= '0;
      req_ready_q        <= 1'b1;
      resp_valid_q       <= 1'b0;
      resp_rdata_q       <= '0;
      resp_err_q         <= 1'b0;
      mem_address_q      <= '0;
      mem_write_data_q   <= '0;
      mem_write_enable_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            we_q        <= req_we;
            wdata_hi_q  <= req_wdata[31:16];
            req_ready_q <= 1'b0;
            if (req_addr[1:0] != 2'b00) begin
              // Misaligned: answer straight away, memory stays untouched.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              // Present the low-half access for the whole LO cycle.
              state_q            <= LO;
              mem_address_q      <= req_addr;
              mem_write_data_q   <= req_wdata[15:0];
              mem_write_enable_q <= req_we;
            end
          end
        end

        LO: begin
          // The memory read is combinational, so the low half is valid now.
          lo_q               <= mem_read_data;
          state_q            <= HI;
          mem_address_q      <= addr_q + HALF_STRIDE;  // wraps mod 2^16
          mem_write_data_q   <= wdata_hi_q;
          mem_write_enable_q <= we_q;
        end

        HI: begin
          state_q            <= RESP;
          mem_address_q      <= '0;
          mem_write_data_q   <= '0;
          mem_write_enable_q <= 1'b0;
          resp_valid_q       <= 1'b1;
          resp_err_q         <= 1'b0;
          resp_rdata_q       <= we_q ? 32'd0 : {mem_read_data, lo_q};
        end

        RESP: begin
          // Hold the response until the requester takes it.
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_err         = resp_err_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;

  // The memory writes on the same edge that samples rst. Gating the enable
  // with rst keeps a reset asserted mid-access from completing the pending
  // half-word write.
  assign mem_write_enable = mem_write_enable_q & ~rst;

endmodule
